// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode tags and result-stage states
package alu_pkg;
  localparam int ALU_SIZE = 16;
  localparam int OPW = 4;
  typedef enum logic [OPW-1:0] {OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_NOT} opcode_t;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;
endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: zero and negative flags of a gate result
module alu_flag_gen #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] result,
  output logic            zero,
  output logic            neg
);
  assign zero = result == '0;
  assign neg = result[SIZE-1];
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered gate-result stage with 2-entry skid buffer and delivery counter
module alu_result_stage #(
  parameter int SIZE = alu_pkg::ALU_SIZE,
  parameter int OPW = alu_pkg::OPW,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_result,
  input  logic [OPW-1:0]  in_opcode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_result,
  output logic [OPW-1:0]  out_opcode,
  output logic            out_zero,
  output logic            out_neg,
  output logic [CNTW-1:0] out_count
);
  import alu_pkg::*;
  state_t state, next;
  logic acc, hs, ld_main, ld_skid, mv, f_zero, f_neg, s_zero, s_neg;
  logic [SIZE-1:0] s_result;
  logic [OPW-1:0] s_opcode;
  // both handshake signals come straight from the state register
  assign in_ready = state != ST_TWO;
  assign out_valid = state != ST_EMPTY;
  assign acc = in_valid && in_ready;
  assign hs = out_valid && out_ready;
  alu_flag_gen #(.SIZE(SIZE)) u_flag (.result(in_result), .zero(f_zero), .neg(f_neg));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_EMPTY;
    else state <= next;
  always_comb begin
    next = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        next = acc ? ST_ONE : ST_EMPTY;
        ld_main = acc;
      end
      ST_ONE: begin
        next = acc && !hs ? ST_TWO : (hs && !acc ? ST_EMPTY : ST_ONE);
        ld_skid = acc && !hs;
        ld_main = acc && hs;
      end
      ST_TWO: begin
        next = hs ? ST_ONE : ST_TWO;
        mv = hs;
      end
      default: next = ST_EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_result <= '0;
      out_opcode <= '0;
      out_zero <= 1'b0;
      out_neg <= 1'b0;
      s_result <= '0;
      s_opcode <= '0;
      s_zero <= 1'b0;
      s_neg <= 1'b0;
      out_count <= '0;
    end else begin
      if (ld_main || mv) begin
        out_result <= mv ? s_result : in_result;
        out_opcode <= mv ? s_opcode : in_opcode;
        out_zero <= mv ? s_zero : f_zero;
        out_neg <= mv ? s_neg : f_neg;
      end
      if (ld_skid) begin
        s_result <= in_result;
        s_opcode <= in_opcode;
        s_zero <= f_zero;
        s_neg <= f_neg;
      end
      out_count <= out_count + CNTW'(hs);
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed vectors against hand-computed expectations
module tb_alu_result_stage;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] in_result = '0, out_result;
  logic [3:0] in_opcode = '0, out_opcode;
  logic out_zero, out_neg;
  logic [7:0] out_count;
  int total = 0, bad = 0;
  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_opcode(in_opcode), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_opcode(out_opcode),
    .out_zero(out_zero), .out_neg(out_neg), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic stream(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_result = 16'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(out_result), 0);
    check("rst_flags", 32'({out_zero, out_neg}), 0);
    check("rst_count", 32'(out_count), 0);
    in_valid = 1'b1; in_result = 16'hFFBF; in_opcode = 4'd2; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_result = 'x; in_opcode = 'x;
    check("nand_valid", 32'(out_valid), 1);
    check("nand_result", 32'(out_result), 32'hFFBF);
    check("nand_opcode", 32'(out_opcode), 2);
    check("nand_neg", 32'(out_neg), 1);
    check("nand_zero", 32'(out_zero), 0);
    tick();
    check("nand_count", 32'(out_count), 1);
    check("nand_empty", 32'(out_valid), 0);
    check("x_hold", 32'(out_result), 32'hFFBF);
    in_valid = 1'b1; in_result = 16'h0000; in_opcode = 4'd2;
    tick();
    in_valid = 1'b0;
    check("zero_result", 32'(out_result), 0);
    check("zero_zero", 32'(out_zero), 1);
    check("zero_neg", 32'(out_neg), 0);
    tick();
    check("zero_count", 32'(out_count), 2);
    out_ready = 1'b0; in_valid = 1'b1; in_result = 16'h1111; in_opcode = 4'd4;
    tick();
    check("skid_ready1", 32'(in_ready), 1);
    in_result = 16'h2222;
    tick();
    check("skid_ready0", 32'(in_ready), 0);
    check("skid_head", 32'(out_result), 32'h1111);
    in_result = 16'h3333;
    tick();
    check("skid_hold", 32'(out_result), 32'h1111);
    check("skid_hold_op", 32'(out_opcode), 4);
    check("skid_still_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    check("skid_second", 32'(out_result), 32'h2222);
    check("skid_reopen", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("skid_third", 32'(out_result), 32'h3333);
    check("skid_third_v", 32'(out_valid), 1);
    tick();
    check("skid_drained", 32'(out_valid), 0);
    check("skid_count", 32'(out_count), 5);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_result = 16'(i);
      tick();
      check("tp_result", 32'(out_result), 32'(i));
      check("tp_valid", 32'(out_valid), 1);
      check("tp_ready", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    tick();
    check("tp_count", 32'(out_count), 25);
    stream(231);
    check("wrap_zero", 32'(out_count), 0);
    stream(1);
    check("wrap_one", 32'(out_count), 1);
    out_ready = 1'b0; in_valid = 1'b1; in_result = 16'h5555;
    tick();
    in_result = 16'h6666;
    tick();
    in_valid = 1'b0;
    check("pre_rst_full", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_ready", 32'(in_ready), 1);
    check("arst_count", 32'(out_count), 0);
    check("arst_result", 32'(out_result), 0);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_empty", 32'(out_valid), 0);
    in_valid = 1'b1; in_result = 16'hABCD; in_opcode = 4'd5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_result", 32'(out_result), 32'hABCD);
    check("post_rst_neg", 32'(out_neg), 1);
    tick();
    check("post_rst_count", 32'(out_count), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
